bus_dma: RTL and testbench

- Word-copy DMA engine on the SoC's 32-bit system bus.
- Acts as a responder to the CPU through a 4-register programming window.
- Acts as a second bus initiator: requests the bus, reads source words from ROM/RAM/peripherals and writes them to destination addresses using the same address/writeEnable/dataIn/dataOut protocol as the CPU.
- The top-level bus mux gives it the bus on busGrant and raises an interrupt flag on completion.

---
 rtl/bus_dma.sv | 180 ++++++++++++++++++
 tb/tb_bus_dma.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_dma.sv
// Word-copy DMA initiator with a 4-register CPU window; optional constant fill via BUS_DMA_FILL_EN.
// Latency READ_LATENCY+2 cycles per copied word (1 per word in fill); stalls in REQ until busGrant.
// Backpressure: none once granted -- the bus is held from REQ through the last WRITE.
module bus_dma #(
    parameter int READ_LATENCY = 1,
    parameter int LEN_WIDTH    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipSelect,
    input  logic [1:0]  regSelect,
    input  logic        regWrite,
    input  logic [31:0] regDataIn,
    output logic [31:0] regDataOut,
    output logic        busRequest,
    input  logic        busGrant,
    output logic [31:0] mAddress,
    output logic        mWriteEnable,
    output logic [31:0] mDataOut,
    input  logic [31:0] mDataIn,
    output logic        irq
);

    typedef enum logic [2:0] {IDLE, REQ, READ, CAPTURE, WRITE, DONE} stateType;

    localparam logic [2:0] WAIT_LAST = 3'(READ_LATENCY - 1);

    stateType             state, nextState;
    logic [31:0]          srcAddr, dstAddr, dataReg, addrHold;
    logic [LEN_WIDTH-1:0] lenCount, lenNext;
    logic [2:0]           waitCount;
    logic                 ie, done, fillReg, fillActive;
    logic                 busy, regWr, ctrlWr, startReq, startGo, clearDone, lastWord;

    assign regWr     = chipSelect & regWrite;
    assign ctrlWr    = regWr && (regSelect == 2'd3);
    assign busy      = (state == REQ) || (state == READ) || (state == CAPTURE) || (state == WRITE);
    assign startReq  = ctrlWr && regDataIn[0] && !busy;
    assign startGo   = startReq && (lenCount != '0);
    assign clearDone = ctrlWr && regDataIn[2];
    assign lenNext   = lenCount - LEN_WIDTH'(1);
    assign lastWord  = (lenNext == '0);
    assign irq       = done & ie;
    assign mDataOut  = dataReg;

    always_comb begin
        regDataOut = 32'h0;
        case (regSelect)
            2'd0:    regDataOut = srcAddr;
            2'd1:    regDataOut = dstAddr;
            2'd2:    regDataOut = 32'(lenCount);
            default: regDataOut = {28'h0, fillReg, ie, done, busy};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState    = state;
        busRequest   = 1'b0;
        mWriteEnable = 1'b0;
        mAddress     = addrHold;
        case (state)
            IDLE, DONE: begin
                nextState = startGo ? REQ : IDLE;
            end
            REQ: begin
                busRequest = 1'b1;
                if (busGrant) begin
                    nextState = fillActive ? WRITE : READ;
                end
            end
            READ: begin
                busRequest = 1'b1;
                mAddress   = srcAddr;
                if (waitCount == WAIT_LAST) begin
                    nextState = CAPTURE;
                end
            end
            CAPTURE: begin
                busRequest = 1'b1;
                mAddress   = srcAddr;
                nextState  = WRITE;
            end
            WRITE: begin
                busRequest   = 1'b1;
                mAddress     = dstAddr;
                mWriteEnable = 1'b1;
                if (lastWord) begin
                    nextState = DONE;
                end else begin
                    nextState = fillActive ? WRITE : READ;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            srcAddr   <= 32'h0;
            dstAddr   <= 32'h0;
            lenCount  <= '0;
            dataReg   <= 32'h0;
            addrHold  <= 32'h0;
            waitCount <= 3'd0;
            ie        <= 1'b0;
            done      <= 1'b0;
        end else begin
            addrHold <= mAddress;
            if (regWr && !busy) begin
                case (regSelect)
                    2'd0:    srcAddr  <= {regDataIn[31:2], 2'b00};
                    2'd1:    dstAddr  <= {regDataIn[31:2], 2'b00};
                    2'd2:    lenCount <= regDataIn[LEN_WIDTH-1:0];
                    default: ;
                endcase
            end
            if (ctrlWr) begin
                ie <= regDataIn[1];
            end
            // Priority, lowest first: clear, then start, then completion.
            if (clearDone) begin
                done <= 1'b0;
            end
            if (startReq) begin
                done <= (lenCount == '0);
            end
            if (state == READ) begin
                waitCount <= waitCount + 3'd1;
            end else begin
                waitCount <= 3'd0;
            end
            if (state == CAPTURE) begin
                dataReg <= mDataIn;
            end
`ifdef BUS_DMA_FILL_EN
            if (startGo && regDataIn[3]) begin
                dataReg <= srcAddr;
            end
`endif
            if (state == WRITE) begin
                if (!fillActive) begin
                    srcAddr <= srcAddr + 32'd4;
                end
                dstAddr  <= dstAddr + 32'd4;
                lenCount <= lenNext;
                if (lastWord) begin
                    done <= 1'b1;
                end
            end
        end
    end

`ifdef BUS_DMA_FILL_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            fillReg    <= 1'b0;
            fillActive <= 1'b0;
        end else begin
            if (ctrlWr) begin
                fillReg <= regDataIn[3];
            end
            if (startGo) begin
                fillActive <= regDataIn[3];
            end
        end
    end
`else
    assign fillReg    = 1'b0;
    assign fillActive = 1'b0;
`endif

endmodule

// File: tb/tb_bus_dma.sv
// Randomized self-checking bench for bus_dma against a transfer-level reference model.
module tb_bus_dma;

    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        chipSelect = 1'b0;
    logic [1:0]  regSelect = 2'd0;
    logic        regWrite = 1'b0;
    logic [31:0] regDataIn = 32'h0;
    logic [31:0] regDataOut;
    logic        busRequest;
    logic        busGrant = 1'b1;
    logic [31:0] mAddress;
    logic        mWriteEnable;
    logic [31:0] mDataOut;
    logic [31:0] mDataIn = 32'h0;
    logic        irq;

    int checkCount = 0;
    int failCount  = 0;
    int cyc        = 0;
    int startCyc   = 0;
    logic sawReq   = 1'b0;

    logic [31:0] addrHist [0:4];
    logic [31:0] wrAddrQ [$];
    logic [31:0] wrDataQ [$];
    int          wrCycQ  [$];

    bus_dma #(.READ_LATENCY(RL), .LEN_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .chipSelect(chipSelect), .regSelect(regSelect),
        .regWrite(regWrite), .regDataIn(regDataIn), .regDataOut(regDataOut),
        .busRequest(busRequest), .busGrant(busGrant), .mAddress(mAddress),
        .mWriteEnable(mWriteEnable), .mDataOut(mDataOut), .mDataIn(mDataIn), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] romWord(input logic [31:0] a);
        return (a >> 2) ^ (a & 32'hFFFF0000);
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Bus responder: read data appears RL cycles after the address; writes are logged.
    initial begin
        for (int i = 0; i < 5; i++) addrHist[i] = 32'h0;
        forever begin
            @(negedge clk);
            for (int i = 4; i > 0; i--) addrHist[i] = addrHist[i-1];
            addrHist[0] = mAddress;
            mDataIn = romWord(addrHist[RL]);
            if (mWriteEnable) begin
                wrAddrQ.push_back(mAddress);
                wrDataQ.push_back(mDataOut);
                wrCycQ.push_back(cyc);
            end
            if (busRequest) sawReq = 1'b1;
        end
    end

    task automatic regWriteOp(input logic [1:0] sel, input logic [31:0] data);
        @(negedge clk);
        chipSelect = 1'b1; regWrite = 1'b1; regSelect = sel; regDataIn = data;
        @(negedge clk);
        chipSelect = 1'b0; regWrite = 1'b0;
    endtask

    task automatic regRead(input logic [1:0] sel, output logic [31:0] v);
        regSelect = sel;
        #1;
        v = regDataOut;
    endtask

    task automatic drivePulse(input logic [1:0] sel, input logic [31:0] data);
        chipSelect = 1'b1; regWrite = 1'b1; regSelect = sel; regDataIn = data;
    endtask

    task automatic clearLog();
        wrAddrQ.delete(); wrDataQ.delete(); wrCycQ.delete();
    endtask

    task automatic doTransfer(input logic [31:0] srcRaw, input logic [31:0] dstRaw, input int len,
                              input int gd, input logic ieBit, input logic clrBit,
                              input logic clearAtEnd, input logic meddle);
        logic [31:0] src, dst, v;
        int lastEdge, errs, completed;
        src = srcRaw & ~32'h3;
        dst = dstRaw & ~32'h3;
        clearLog();
        busGrant = (gd == 0);
        regWriteOp(2'd0, srcRaw);
        regWriteOp(2'd1, dstRaw);
        regWriteOp(2'd2, 32'(len));
        regWriteOp(2'd3, {29'h0, clrBit, ieBit, 1'b1});
        startCyc = cyc;
        lastEdge = 1 + gd + len * (RL + 2);
        errs = 0;
        for (int k = 0; k <= lastEdge; k++) begin
            chipSelect = 1'b0; regWrite = 1'b0;
            if (k == gd) busGrant = 1'b1;
            if (k < gd && (!busRequest || mWriteEnable)) errs++;
            if (k == 0) begin
                regRead(2'd3, v);
                checkEq("startCtrl", v, 32'h1 | (32'(ieBit) << 2));
            end
            completed = (k < 1 + gd) ? 0 : (k - 1 - gd) / (RL + 2);
            if (completed > len) completed = len;
            regRead(2'd2, v);
            if (v != 32'(len - completed)) errs++;
            if (k == lastEdge - 1) begin
                regRead(2'd3, v);
                checkEq("busyBeforeEnd", {31'h0, v[0]}, 32'h1);
                checkEq("reqBeforeEnd", {31'h0, busRequest}, 32'h1);
                if (clearAtEnd) drivePulse(2'd3, {29'h0, 1'b1, ieBit, 1'b0});
            end
            if (meddle) begin
                if (k == 3) drivePulse(2'd0, 32'hDEADBEEC);
                if (k == 6) drivePulse(2'd3, {30'h0, ieBit, 1'b1});
                if (k == 9) drivePulse(2'd2, 32'h55);
            end
            @(negedge clk);
        end
        chipSelect = 1'b0; regWrite = 1'b0;
        checkEq("lenTrackErrs", 32'(errs), 32'h0);
        regRead(2'd3, v);
        checkEq("endCtrl", v, 32'h2 | (32'(ieBit) << 2));
        checkEq("endIrq", {31'h0, irq}, {31'h0, ieBit});
        checkEq("endReq", {31'h0, busRequest}, 32'h0);
        regRead(2'd0, v);
        checkEq("endSrc", v, src + 32'(4 * len));
        regRead(2'd1, v);
        checkEq("endDst", v, dst + 32'(4 * len));
        checkEq("writeCount", 32'(wrAddrQ.size()), 32'(len));
        for (int j = 0; j < len && j < wrAddrQ.size(); j++) begin
            checkEq("wrAddr", wrAddrQ[j], dst + 32'(4 * j));
            checkEq("wrData", wrDataQ[j], romWord(src + 32'(4 * j)));
            checkEq("wrCycle", 32'(wrCycQ[j]), 32'(startCyc + gd + (j + 1) * (RL + 2)));
        end
    endtask

    initial begin
        logic [31:0] v, s, d;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        checkEq("rstReq", {31'h0, busRequest}, 32'h0);
        checkEq("rstWe", {31'h0, mWriteEnable}, 32'h0);
        checkEq("rstAddr", mAddress, 32'h0);
        checkEq("rstDout", mDataOut, 32'h0);
        checkEq("rstIrq", {31'h0, irq}, 32'h0);
        for (int r = 0; r < 4; r++) begin
            regRead(2'(r), v);
            checkEq("rstReg", v, 32'h0);
        end
        reset = 1'b1;
        @(negedge clk);

        // Directed copy, grant delay, busy protection, completion-vs-clear
        doTransfer(32'h00000100, 32'h00010000, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        doTransfer(32'h00000300, 32'h00018000, 3, 10, 1'b1, 1'b1, 1'b0, 1'b0);
        doTransfer(32'h00000400, 32'h0001C000, 8, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        doTransfer(32'h00000503, 32'h0001D002, 2, 1, 1'b1, 1'b0, 1'b1, 1'b0);

        // Randomized transfers, first one wrapping past the top of the address space
        for (int i = 0; i < 8; i++) begin
            s = (i == 0) ? (32'hFFFFFFF8 | 32'($urandom_range(0, 3))) : $urandom;
            d = $urandom;
            n = $urandom_range(1, 6);
            doTransfer(s, d, n, $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'b0);
        end

        // Zero length start
        sawReq = 1'b0;
        clearLog();
        regWriteOp(2'd2, 32'h0);
        regWriteOp(2'd3, 32'h3);
        regRead(2'd3, v);
        checkEq("zeroCtrl", v, 32'h6);
        checkEq("zeroIrq", {31'h0, irq}, 32'h1);
        repeat (5) @(negedge clk);
        checkEq("zeroNoReq", {31'h0, sawReq}, 32'h0);
        checkEq("zeroNoWrites", 32'(wrAddrQ.size()), 32'h0);
        regWriteOp(2'd3, 32'h4);
        regRead(2'd3, v);
        checkEq("zeroClrCtrl", v, 32'h0);
        checkEq("zeroClrIrq", {31'h0, irq}, 32'h0);
        regWriteOp(2'd3, 32'h3);
        regWriteOp(2'd3, 32'h6);
        regRead(2'd3, v);
        checkEq("doneClrKeepIe", v, 32'h4);

        // Fill flag
        regWriteOp(2'd3, 32'hC);
        regRead(2'd3, v);
`ifdef BUS_DMA_FILL_EN
        checkEq("fillReadback", v, 32'h8);
        clearLog();
        regWriteOp(2'd0, 32'hA5A5A5A4);
        regWriteOp(2'd1, 32'h00010020);
        regWriteOp(2'd2, 32'h3);
        regWriteOp(2'd3, 32'h9);
        startCyc = cyc;
        repeat (6) @(negedge clk);
        checkEq("fillCount", 32'(wrAddrQ.size()), 32'h3);
        for (int j = 0; j < 3 && j < wrAddrQ.size(); j++) begin
            checkEq("fillAddr", wrAddrQ[j], 32'h00010020 + 32'(4 * j));
            checkEq("fillData", wrDataQ[j], 32'hA5A5A5A4);
            checkEq("fillCycle", 32'(wrCycQ[j]), 32'(startCyc + 1 + j));
        end
        regRead(2'd0, v);
        checkEq("fillSrcHeld", v, 32'hA5A5A5A4);
        regWriteOp(2'd3, 32'h4);
`else
        checkEq("fillReadback", v, 32'h0);
`endif

        // Reset during the WRITE of word 2 of 5
        clearLog();
        busGrant = 1'b1;
        regWriteOp(2'd0, 32'h00000200);
        regWriteOp(2'd1, 32'h00020000);
        regWriteOp(2'd2, 32'h5);
        regWriteOp(2'd3, 32'h3);
        repeat (2 * (RL + 2)) @(negedge clk);
        checkEq("midWriteActive", {31'h0, mWriteEnable}, 32'h1);
        reset = 1'b0;
        @(negedge clk);
        checkEq("midRstReq", {31'h0, busRequest}, 32'h0);
        checkEq("midRstWe", {31'h0, mWriteEnable}, 32'h0);
        checkEq("midRstAddr", mAddress, 32'h0);
        checkEq("midRstIrq", {31'h0, irq}, 32'h0);
        for (int r = 0; r < 4; r++) begin
            regRead(2'(r), v);
            checkEq("midRstReg", v, 32'h0);
        end
        reset = 1'b1;
        sawReq = 1'b0;
        repeat (30) @(negedge clk);
        checkEq("midRstWrites", 32'(wrAddrQ.size()), 32'h2);
        checkEq("midRstNoReq", {31'h0, sawReq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
